// File: rtl/wb_regfile_pkg.sv
// Shared pipeline definitions for the writeback stage and the control unit.
// Holds register-file geometry and the writeback-select encoding.
package wb_regfile_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int         NUM_REGS = 32;

  typedef enum logic {
    WB_SEL_ALU = 1'b0,
    WB_SEL_MEM = 1'b1
  } wb_sel_e;

endpackage

// File: rtl/wb_regfile_read_port.sv
// One ID-stage source-operand read: zero forcing for R0 plus a write-through
// bypass of the writeback value committed in the same cycle.
module regfile_read_port
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] stored,
  input  logic              commit,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] data
);

  always_comb begin
    data = stored;
    if (addr == ADDR_W'(REG_ZERO)) begin
      data = '0;
    end else if (commit && (addr == wr_addr)) begin
      data = wr_data;
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: selects the writeback value, commits it to the GPR file,
// and serves the two ID-stage reads plus a debug read and a retired-write count.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] dout_WB,
  input  logic [DATA_W-1:0] ALUResult_WB,
  input  logic [ADDR_W-1:0] RdOrRt_WB,
  input  logic              RegWrite_WB,
  input  logic              MemtoReg_WB,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [DATA_W-1:0] wb_data,
  output logic [31:0]       wr_count
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic              commit;
  wb_sel_e           wb_sel;

  assign wb_sel = wb_sel_e'(MemtoReg_WB);

  always_comb begin
    wb_data = ALUResult_WB;
    if (wb_sel == WB_SEL_MEM) begin
      wb_data = dout_WB;
    end
  end

  // Gating on reset keeps a write presented during reset from being bypassed
  // or stored; R0 is never written so its array slot stays at zero.
  assign commit = reset && RegWrite_WB && (RdOrRt_WB != ADDR_W'(REG_ZERO));

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      wr_count <= '0;
    end else if (commit) begin
      regs[RdOrRt_WB] <= wb_data;
      wr_count        <= wr_count + 32'd1;
    end
  end

  regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rs_port (
    .addr    (rs_addr),
    .stored  (regs[rs_addr]),
    .commit  (commit),
    .wr_addr (RdOrRt_WB),
    .wr_data (wb_data),
    .data    (rs_data)
  );

  regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rt_port (
    .addr    (rt_addr),
    .stored  (regs[rt_addr]),
    .commit  (commit),
    .wr_addr (RdOrRt_WB),
    .wr_data (wb_data),
    .data    (rt_data)
  );

  assign dbg_data = regs[dbg_addr];

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios followed by random
// traffic checked against an array-based model of the register file.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] dout_WB, ALUResult_WB;
  logic [4:0]  RdOrRt_WB;
  logic        RegWrite_WB, MemtoReg_WB;
  logic [4:0]  rs_addr, rt_addr, dbg_addr;
  logic [31:0] rs_data, rt_data, dbg_data, wb_data, wr_count;

  int total = 0;
  int bad   = 0;

  logic [31:0] model [32];
  logic [31:0] mcount;

  wb_regfile dut (
    .clk          (clk),
    .reset        (reset),
    .dout_WB      (dout_WB),
    .ALUResult_WB (ALUResult_WB),
    .RdOrRt_WB    (RdOrRt_WB),
    .RegWrite_WB  (RegWrite_WB),
    .MemtoReg_WB  (MemtoReg_WB),
    .rs_addr      (rs_addr),
    .rt_addr      (rt_addr),
    .rs_data      (rs_data),
    .rt_data      (rt_data),
    .dbg_addr     (dbg_addr),
    .dbg_data     (dbg_data),
    .wb_data      (wb_data),
    .wr_count     (wr_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_wb();
    return MemtoReg_WB ? dout_WB : ALUResult_WB;
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (reset && RegWrite_WB && RdOrRt_WB != 5'd0 && RdOrRt_WB == a) return exp_wb();
    return model[a];
  endfunction

  // Inputs change only just after a falling edge, so they are stable here.
  task automatic tick();
    @(posedge clk);
    if (!reset) begin
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
      mcount = 32'd0;
    end else if (RegWrite_WB && RdOrRt_WB != 5'd0) begin
      model[RdOrRt_WB] = exp_wb();
      mcount = mcount + 32'd1;
    end
    @(negedge clk);
  endtask

  task automatic randomize_inputs();
    dout_WB      = $urandom;
    ALUResult_WB = $urandom;
    RdOrRt_WB    = 5'($urandom_range(0, 31));
    RegWrite_WB  = 1'($urandom);
    MemtoReg_WB  = 1'($urandom);
    rs_addr      = 5'($urandom_range(0, 31));
    rt_addr      = ($urandom_range(0, 3) == 0) ? RdOrRt_WB : 5'($urandom_range(0, 31));
    dbg_addr     = 5'($urandom_range(0, 31));
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      randomize_inputs();
      RegWrite_WB = 1'b1;
      tick();
      randomize_inputs();
      RegWrite_WB = 1'b1;
      #1;
      total++; if (rs_data !== 32'd0) begin bad++; $display("FAIL reset_rs got=%h exp=%h", rs_data, 32'd0); end
      total++; if (rt_data !== 32'd0) begin bad++; $display("FAIL reset_rt got=%h exp=%h", rt_data, 32'd0); end
      total++; if (dbg_data !== 32'd0) begin bad++; $display("FAIL reset_dbg got=%h exp=%h", dbg_data, 32'd0); end
      total++; if (wr_count !== 32'd0) begin bad++; $display("FAIL reset_count got=%h exp=%h", wr_count, 32'd0); end
    end
    reset = 1'b1;
    RegWrite_WB = 1'b0;
    tick();
  endtask

  task automatic test_alu_commit();
    RegWrite_WB = 1'b1; RdOrRt_WB = 5'd5; MemtoReg_WB = 1'b0;
    ALUResult_WB = 32'h1234; dout_WB = 32'hCAFE0000;
    #1;
    total++; if (wb_data !== 32'h1234) begin bad++; $display("FAIL alu_wb_data got=%h exp=%h", wb_data, 32'h1234); end
    tick();
    RegWrite_WB = 1'b0; dbg_addr = 5'd5;
    #1;
    total++; if (dbg_data !== 32'h1234) begin bad++; $display("FAIL alu_dbg got=%h exp=%h", dbg_data, 32'h1234); end
    total++; if (wr_count !== 32'd1) begin bad++; $display("FAIL alu_count got=%0d exp=%0d", wr_count, 1); end
  endtask

  task automatic test_load_commit();
    RegWrite_WB = 1'b1; RdOrRt_WB = 5'd9; MemtoReg_WB = 1'b1;
    dout_WB = 32'hDEADBEEF; ALUResult_WB = 32'h1;
    #1;
    total++; if (wb_data !== 32'hDEADBEEF) begin bad++; $display("FAIL load_wb_data got=%h exp=%h", wb_data, 32'hDEADBEEF); end
    tick();
    RegWrite_WB = 1'b0; rs_addr = 5'd9; dbg_addr = 5'd9;
    #1;
    total++; if (rs_data !== 32'hDEADBEEF) begin bad++; $display("FAIL load_rs got=%h exp=%h", rs_data, 32'hDEADBEEF); end
    total++; if (dbg_data !== 32'hDEADBEEF) begin bad++; $display("FAIL load_dbg got=%h exp=%h", dbg_data, 32'hDEADBEEF); end
    total++; if (wr_count !== 32'd2) begin bad++; $display("FAIL load_count got=%0d exp=%0d", wr_count, 2); end
  endtask

  task automatic test_bypass();
    RegWrite_WB = 1'b1; RdOrRt_WB = 5'd7; MemtoReg_WB = 1'b0; ALUResult_WB = 32'h11;
    tick();
    ALUResult_WB = 32'h22; rs_addr = 5'd7; rt_addr = 5'd7; dbg_addr = 5'd7;
    #1;
    total++; if (rs_data !== 32'h22) begin bad++; $display("FAIL bypass_rs got=%h exp=%h", rs_data, 32'h22); end
    total++; if (rt_data !== 32'h22) begin bad++; $display("FAIL bypass_rt got=%h exp=%h", rt_data, 32'h22); end
    total++; if (dbg_data !== 32'h11) begin bad++; $display("FAIL bypass_dbg_old got=%h exp=%h", dbg_data, 32'h11); end
    tick();
    RegWrite_WB = 1'b0;
    #1;
    total++; if (dbg_data !== 32'h22) begin bad++; $display("FAIL bypass_dbg_new got=%h exp=%h", dbg_data, 32'h22); end
    total++; if (rs_data !== 32'h22) begin bad++; $display("FAIL bypass_rs_stored got=%h exp=%h", rs_data, 32'h22); end
    total++; if (wr_count !== 32'd4) begin bad++; $display("FAIL bypass_count got=%0d exp=%0d", wr_count, 4); end
  endtask

  task automatic test_r0_write();
    RegWrite_WB = 1'b1; RdOrRt_WB = 5'd0; MemtoReg_WB = 1'b0; ALUResult_WB = 32'hFFFFFFFF;
    rs_addr = 5'd0; rt_addr = 5'd0; dbg_addr = 5'd0;
    #1;
    total++; if (rs_data !== 32'd0) begin bad++; $display("FAIL r0_rs_same got=%h exp=%h", rs_data, 32'd0); end
    total++; if (rt_data !== 32'd0) begin bad++; $display("FAIL r0_rt_same got=%h exp=%h", rt_data, 32'd0); end
    tick();
    RegWrite_WB = 1'b0;
    #1;
    total++; if (dbg_data !== 32'd0) begin bad++; $display("FAIL r0_dbg got=%h exp=%h", dbg_data, 32'd0); end
    total++; if (rs_data !== 32'd0) begin bad++; $display("FAIL r0_rs got=%h exp=%h", rs_data, 32'd0); end
    total++; if (wr_count !== 32'd4) begin bad++; $display("FAIL r0_count got=%0d exp=%0d", wr_count, 4); end
  endtask

  task automatic test_reset_with_commit();
    reset = 1'b0;
    RegWrite_WB = 1'b1; RdOrRt_WB = 5'd3; MemtoReg_WB = 1'b0; ALUResult_WB = 32'h55;
    rs_addr = 5'd3; rt_addr = 5'd7; dbg_addr = 5'd3;
    #1;
    total++; if (rs_data !== 32'd0) begin bad++; $display("FAIL rstw_no_bypass got=%h exp=%h", rs_data, 32'd0); end
    total++; if (rt_data !== 32'h22) begin bad++; $display("FAIL rstw_stored got=%h exp=%h", rt_data, 32'h22); end
    tick();
    #1;
    total++; if (dbg_data !== 32'd0) begin bad++; $display("FAIL rstw_r3 got=%h exp=%h", dbg_data, 32'd0); end
    total++; if (rt_data !== 32'd0) begin bad++; $display("FAIL rstw_r7 got=%h exp=%h", rt_data, 32'd0); end
    total++; if (wr_count !== 32'd0) begin bad++; $display("FAIL rstw_count got=%0d exp=%0d", wr_count, 0); end
    reset = 1'b1; ALUResult_WB = 32'h66;
    tick();
    RegWrite_WB = 1'b0;
    #1;
    total++; if (dbg_data !== 32'h66) begin bad++; $display("FAIL rstw_first_write got=%h exp=%h", dbg_data, 32'h66); end
    total++; if (wr_count !== 32'd1) begin bad++; $display("FAIL rstw_first_count got=%0d exp=%0d", wr_count, 1); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      randomize_inputs();
      reset = ($urandom_range(0, 49) != 0);
      #1;
      total++; if (wb_data !== exp_wb()) begin bad++; $display("FAIL rand_wb c=%0d got=%h exp=%h", c, wb_data, exp_wb()); end
      total++; if (rs_data !== exp_read(rs_addr)) begin bad++; $display("FAIL rand_rs c=%0d a=%0d got=%h exp=%h", c, rs_addr, rs_data, exp_read(rs_addr)); end
      total++; if (rt_data !== exp_read(rt_addr)) begin bad++; $display("FAIL rand_rt c=%0d a=%0d got=%h exp=%h", c, rt_addr, rt_data, exp_read(rt_addr)); end
      total++; if (dbg_data !== model[dbg_addr]) begin bad++; $display("FAIL rand_dbg c=%0d a=%0d got=%h exp=%h", c, dbg_addr, dbg_data, model[dbg_addr]); end
      total++; if (wr_count !== mcount) begin bad++; $display("FAIL rand_count c=%0d got=%0d exp=%0d", c, wr_count, mcount); end
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    mcount = 32'd0;
    reset = 1'b0;
    randomize_inputs();
    @(negedge clk);
    test_reset();
    test_alu_commit();
    test_load_commit();
    test_bypass();
    test_r0_write();
    test_reset_with_commit();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Writeback-stage consumer of the MEM/WB pipeline register: selects the writeback value (load data or ALU result), commits it to the 32×32 MIPS general-purpose register file, and serves the two ID-stage source-operand reads. A same-cycle write-through bypass resolves the ID/WB hazard without a stall. A retired-write counter and a debug read port support the bench and FPGA bring-up.

## Interface
- `DATA_W`, default 32: register width.
- `ADDR_W`, default 5: register index width; the file holds 2^ADDR_W entries.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-low; sampled on the `clk` rising edge.
- `dout_WB` input DATA_W: load data from MEM/WB.
- `ALUResult_WB` input DATA_W: ALU result from MEM/WB.
- `RdOrRt_WB` input ADDR_W: destination register index.
- `RegWrite_WB` input 1: write enable.
- `MemtoReg_WB` input 1: 1 selects `dout_WB`, 0 selects `ALUResult_WB`.
- `rs_addr`, `rt_addr` input ADDR_W: ID-stage source indices.
- `rs_data`, `rt_data` output DATA_W: source operands (combinational).
- `dbg_addr` input ADDR_W: debug read index.
- `dbg_data` output DATA_W: debug read, stored value only, no bypass.
- `wb_data` output DATA_W: the selected writeback value, for EX forwarding (combinational).
- `wr_count` output 32: number of committed writes.

## Operation
- `wb_data` = `MemtoReg_WB ? dout_WB : ALUResult_WB`. It is always driven, whatever the state of `RegWrite_WB`.
- Commit condition: `reset`=1 and `RegWrite_WB`=1 and `RdOrRt_WB`≠0. On a commit, `regs[RdOrRt_WB]` ← `wb_data` at the rising edge.
- Register 0 is hardwired to zero.
  - Writes to index 0 are discarded.
  - Reads of index 0 return 0 on all ports.
- Read ports `rs_data`/`rt_data`:
  - Address 0: return 0.
  - Address equals `RdOrRt_WB` while the commit condition holds: return `wb_data` (write-through bypass).
  - Otherwise: return `regs[addr]`.
  - Both ports bypass independently; `rs_addr`=`rt_addr` is legal.
- `wr_count` increments by 1 on every commit.
  - Writes to index 0 are not counted.
  - The counter wraps from 0xFFFFFFFF to 0.
- Reset (`reset`=0 at an edge):
  - All 32 registers clear to 0 and `wr_count` clears to 0.
  - A write presented in the same cycle is dropped.
  - While `reset` is low, the bypass is disabled, so reads return stored values, which are 0 after the first reset edge.
- Mid-operation reset: state is cleared on the edge. The first write accepted is the one presented in the first cycle with `reset`=1.

## Timing
- Write latency: one edge. The value is visible through `regs` from the cycle after the commit edge, and through the bypass in the commit cycle itself.
- Read latency: 0 cycles. `rs_data`, `rt_data`, `dbg_data` and `wb_data` are combinational from their inputs and from the register state.
- `dbg_data` reflects the commit one cycle later; it has no bypass.
- `wr_count` is registered and updates on the commit edge.
- Reset values of all registered outputs: `wr_count`=0, all registers 0, hence `dbg_data`=0.
- No handshake: the WB stage cannot stall, and a commit is accepted every cycle.

## Structure
- Shared pipeline package holds:
  - `REG_ZERO` = 5'd0.
  - `NUM_REGS` = 32.
  - The writeback-select encoding (`WB_SEL_ALU`=0, `WB_SEL_MEM`=1), shared with the control unit.
- One sub-module, `regfile_read_port`: address compare plus bypass mux plus zero forcing. It is instantiated twice, for rs and rt. The debug port reads the array directly.

## Test plan
- Reset with all inputs toggling → every `rs_data`/`rt_data`/`dbg_data` read returns 0; `wr_count`=0.
- Commit to R5: `RegWrite_WB`=1, `RdOrRt_WB`=5, `MemtoReg_WB`=0, `ALUResult_WB`=0x1234 → the next cycle, `dbg_addr`=5 gives 0x1234; `wr_count`=1.
- Load writeback: `MemtoReg_WB`=1, `dout_WB`=0xDEADBEEF, `ALUResult_WB`=0x1, `RdOrRt_WB`=9 → `wb_data`=0xDEADBEEF; R9 reads 0xDEADBEEF afterwards.
- Same-cycle bypass: R7 holds 0x11 and a commit of 0x22 to R7 is presented with `rs_addr`=`rt_addr`=7 → both ports show 0x22 in that cycle; `dbg_data` shows 0x11 in that cycle and 0x22 after the edge.
- Write to R0: `RegWrite_WB`=1, `RdOrRt_WB`=0, value 0xFFFFFFFF → R0 reads 0 on all ports; `wr_count` is unchanged.
- Reset in the same cycle as a commit of 0x55 to R3 → R3 is 0 after the edge; no bypass is seen during reset; `wr_count`=0. Wrap check: force 2^32 commits (or preload via a bench override) → `wr_count` goes from 0xFFFFFFFF to 0.
